// File: rtl/dout_sink_pkg.sv
// dout_sink_pkg: shared widths and FIFO entry layout for dout_sink (DOUT_SINK_TS_EN adds a timestamp field)
package dout_sink_pkg;
    localparam int DOUT_W = 8;
    localparam int TS_W   = 16;
`ifdef DOUT_SINK_TS_EN
    typedef struct packed {
        logic [TS_W-1:0]   ts;
        logic [DOUT_W-1:0] data;
    } entry_t;
`else
    typedef struct packed {
        logic [DOUT_W-1:0] data;
    } entry_t;
`endif
endpackage

// File: rtl/dout_sink_sync_fifo.sv
// sync_fifo: synchronous FIFO with wrap-bit pointers; push while full is accepted only alongside a pop
module sync_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  T                         din_i,
    output T                         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] wr_q, rd_q;
    logic        do_push, do_pop;
    T            mem [DEPTH];
    assign full_o  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
    assign empty_o = wr_q == rd_q;
    assign count_o = wr_q - rd_q;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = mem[rd_q[AW-1:0]];
    // pointer advance; the MSB acts as the wrap bit separating full from empty
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end
    // storage write; contents need no reset because empty masks them
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_q[AW-1:0]] <= din_i;
    end
endmodule

// File: rtl/dout_sink.sv
// dout_sink: queues every change of the core debug byte and raises int_o at a fill threshold (DOUT_SINK_TS_EN adds timestamps)
module dout_sink
    import dout_sink_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int IRQ_THRESH = 12,
    parameter int TS_WIDTH   = TS_W
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [DOUT_W-1:0]        data_i,
    input  logic                     en_i,
    input  logic                     m_ready_i,
    output logic                     m_valid_o,
    output logic [DOUT_W-1:0]        m_data_o,
`ifdef DOUT_SINK_TS_EN
    output logic [TS_WIDTH-1:0]      m_ts_o,
`endif
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic                     int_o
);
    localparam int CW = $clog2(DEPTH) + 1;
    if (IRQ_THRESH < 1 || IRQ_THRESH > DEPTH || DEPTH < 2 || (1 << (CW - 1)) != DEPTH || TS_WIDTH != TS_W) begin : g_bad_params
        $error("dout_sink: unsupported parameter combination");
    end
    logic [DOUT_W-1:0] prev_q;
    logic              ovf_q, int_q, chg, pop, push_ok, full, empty;
    logic [CW-1:0]     count, count_d;
    entry_t            din, dout;
    assign chg     = en_i && (data_i != prev_q);
    assign pop     = !empty && m_ready_i;
    assign push_ok = chg && (!full || pop);
    assign count_d = count + CW'(push_ok) - CW'(pop);
    sync_fifo #(.T(entry_t), .DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (chg),
        .pop_i   (pop),
        .din_i   (din),
        .dout_o  (dout),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );
`ifdef DOUT_SINK_TS_EN
    logic [TS_WIDTH-1:0] ts_q;
    // free-running cycle counter stamped into each entry on its push edge
    always_ff @(posedge clk_i) begin
        ts_q <= rst_i ? '0 : ts_q + 1'b1;
    end
    assign m_ts_o = empty ? '0 : dout.ts;
`endif
    // assemble the entry written on a push
    always_comb begin
        din      = '0;
        din.data = data_i;
`ifdef DOUT_SINK_TS_EN
        din.ts   = ts_q;
`endif
    end
    // change tracking, sticky overflow and the interrupt registered from the next fill level
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= '0;
            ovf_q  <= 1'b0;
            int_q  <= 1'b0;
        end else begin
            if (en_i) prev_q <= data_i;
            if (chg && !push_ok) ovf_q <= 1'b1;
            int_q <= count_d >= CW'(IRQ_THRESH);
        end
    end
    assign m_valid_o  = !empty;
    assign m_data_o   = empty ? '0 : dout.data;
    assign count_o    = count;
    assign overflow_o = ovf_q;
    assign int_o      = int_q;
endmodule

// File: tb/tb_dout_sink.sv
// tb_dout_sink: directed vector table plus hand sequences for fill, full-with-pop, wrap and reset
module tb_dout_sink;
    logic       clk = 1'b0, rst = 1'b1, en = 1'b1, ready = 1'b0;
    logic [7:0] d = 8'h00;
    logic       valid, ovf, irq;
    logic [7:0] mdata;
    logic [4:0] cnt;
`ifdef DOUT_SINK_TS_EN
    logic [15:0] ts;
`endif
    int nvec = 0, nbad = 0;

    dout_sink #(.DEPTH(16), .IRQ_THRESH(12)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .data_i     (d),
        .en_i       (en),
        .m_ready_i  (ready),
        .m_valid_o  (valid),
        .m_data_o   (mdata),
`ifdef DOUT_SINK_TS_EN
        .m_ts_o     (ts),
`endif
        .count_o    (cnt),
        .overflow_o (ovf),
        .int_o      (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic v, input logic [7:0] dat, input int c, input logic o, input logic i);
        chk({tag, ".valid"}, 32'(valid), 32'(v));
        if (v) chk({tag, ".data"}, 32'(mdata), 32'(dat));
        chk({tag, ".count"}, 32'(cnt), 32'(c));
        chk({tag, ".ovf"}, 32'(ovf), 32'(o));
        chk({tag, ".int"}, 32'(irq), 32'(i));
    endtask

    typedef struct {
        logic       rst, en;
        logic [7:0] d;
        logic       rdy;
        int         n;
        logic       v;
        logic [7:0] dat;
        int         c;
        logic       o, i;
    } vec_t;

    vec_t tbl[11];
    logic [7:0] q[$];
    logic [7:0] prev_m;
    int sent, sz;
    logic push_m, pop_m;

    initial begin
        tbl = '{
            '{1'b1, 1'b1, 8'h00, 1'b0,  2, 1'b0, 8'h00, 0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 8'h00, 1'b0,  2, 1'b0, 8'h00, 0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 8'h05, 1'b0,  1, 1'b1, 8'h05, 1, 1'b0, 1'b0},
            '{1'b0, 1'b1, 8'h05, 1'b0, 20, 1'b1, 8'h05, 1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 8'h09, 1'b0,  1, 1'b1, 8'h05, 1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 8'h05, 1'b0,  1, 1'b1, 8'h05, 1, 1'b0, 1'b0},
            '{1'b0, 1'b1, 8'h05, 1'b0,  2, 1'b1, 8'h05, 1, 1'b0, 1'b0},
            '{1'b0, 1'b1, 8'h07, 1'b0,  1, 1'b1, 8'h05, 2, 1'b0, 1'b0},
            '{1'b0, 1'b1, 8'h07, 1'b1,  1, 1'b1, 8'h07, 1, 1'b0, 1'b0},
            '{1'b0, 1'b1, 8'h07, 1'b1,  1, 1'b0, 8'h00, 0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 8'h07, 1'b0,  2, 1'b0, 8'h00, 0, 1'b0, 1'b0}
        };
        for (int i = 0; i < 11; i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                rst = tbl[i].rst; en = tbl[i].en; d = tbl[i].d; ready = tbl[i].rdy;
                tick();
                check_state($sformatf("v%0d.%0d", i, k), tbl[i].v, tbl[i].dat, tbl[i].c, tbl[i].o, tbl[i].i);
            end
        end

        // fill past capacity: threshold crossing, full, drop of the 17th byte
        rst = 1'b1; tick(); rst = 1'b0; ready = 1'b0; en = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            d = 8'(k);
            tick();
            check_state($sformatf("fill%0d", k), 1'b1, 8'h01, (k > 16) ? 16 : k, k == 17, ((k > 16) ? 16 : k) >= 12);
        end

        // push and pop on the same edge while full
        d = 8'h12; ready = 1'b1;
        tick();
        check_state("fullpop", 1'b1, 8'h02, 16, 1'b1, 1'b1);
        for (int j = 0; j < 16; j++) begin
            check_state($sformatf("drain%0d", j), 1'b1, (j < 15) ? 8'(j + 2) : 8'h12, 16 - j, 1'b1, (16 - j) >= 12);
            tick();
        end
        check_state("drained", 1'b0, 8'h00, 0, 1'b1, 1'b0);

        // 40 bytes with random back-pressure against a queue scoreboard
        rst = 1'b1; tick(); rst = 1'b0; ready = 1'b0;
        q.delete(); prev_m = 8'h00; sent = 0;
        for (int cyc = 0; cyc < 3000 && (sent < 40 || q.size() != 0); cyc++) begin
            if (sent < 40 && $urandom_range(0, 1) == 1) begin
                d = 8'h20 + 8'(sent);
                sent++;
            end
            ready = $urandom_range(0, 3) != 0;
            sz = q.size();
            pop_m = (sz != 0) && ready;
            push_m = en && (d != prev_m);
            prev_m = d;
            if (pop_m) void'(q.pop_front());
            if (push_m && (sz < 16 || pop_m)) q.push_back(d);
            tick();
            chk($sformatf("rnd%0d.count", cyc), 32'(cnt), 32'(q.size()));
            chk($sformatf("rnd%0d.valid", cyc), 32'(valid), 32'(q.size() != 0));
            if (q.size() != 0) chk($sformatf("rnd%0d.data", cyc), 32'(mdata), 32'(q[0]));
        end
        chk("rnd.all_sent", 32'(sent), 32'd40);
        chk("rnd.empty", 32'(cnt), 32'd0);

        // overflow again, then reset mid-stream
        ready = 1'b0;
        for (int k = 0; k < 17; k++) begin
            d = 8'h80 + 8'(k);
            tick();
        end
        check_state("refill", 1'b1, 8'h80, 16, 1'b1, 1'b1);
        rst = 1'b1;
        tick();
        check_state("midrst", 1'b0, 8'h00, 0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        check_state("postrst", 1'b1, 8'h90, 1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
